// File: rtl/instr_fetch.sv
// RV32I fetch stage: holds the PC, keeps one instruction-memory request in flight,
// and hands each returned word to decode over a valid/ready handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op_code,
  output logic [2:0]  func3,
  output logic [6:0]  func7
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        req_valid_q, req_valid_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] redirect_target;
  logic        unused_redirect_bits;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Redirect wins in every state; drop marks a response already owed by memory
  // that belongs to the old path and must be swallowed.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redirect_target;
      end
      S_REQ: begin
        if (redirect_valid) pc_d = redirect_target;
        if (imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d       = imem_rsp_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else if (instr_ready) begin
          pc_d          = pc_q + 32'd4;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC_W;
      drop_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP;
      instr_pc_q    <= RESET_PC_W;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign op_code        = instr_q[6:0];
  assign func3          = instr_q[14:12];
  assign func7          = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed reset/sequence/backpressure/redirect scenarios, then
// randomized traffic checked by a scoreboard against a fetch-stream reference model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op_code;
  logic [2:0]  func3;
  logic [6:0]  func7;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op_code        (op_code),
    .func3          (func3),
    .func7          (func7)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Instruction memory contents: explicit words where a scenario needs them,
  // otherwise a per-address scramble so a stale word never matches the wanted one.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  // Expected PC of the next instruction decode should see; the word follows from mem_word.
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc = RESET_PC;

  // Memory responder knobs
  bit          mem_manual = 1'b0;
  bit          mem_ready_always = 1'b1;
  bit          mem_spurious = 1'b0;
  int          mem_dmin = 0;
  int          mem_dmax = 0;
  bit          man_ready = 1'b1;
  bit          man_rsp_valid = 1'b0;
  logic [31:0] man_rsp_data = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic failTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input string name, input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (instr_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) failTimeout(name);
  endtask

  // Single-outstanding memory: one response per accepted request after a random delay,
  // optional junk responses while nothing is owed, or manual drive for directed cases.
  initial begin : mem_model
    bit          acc;
    bit          pend;
    int          cnt;
    logic [31:0] acc_addr;
    logic [31:0] pend_addr;
    acc = 1'b0; pend = 1'b0; cnt = 0; acc_addr = '0; pend_addr = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc      = (imem_req_valid === 1'b1) && imem_req_ready && !rst;
      acc_addr = imem_addr;
      @(posedge clk);
      #1;
      if (mem_manual) begin
        pend = 1'b0;
        #1;
        imem_req_ready = man_ready;
        imem_rsp_valid = man_rsp_valid;
        imem_rsp_data  = man_rsp_data;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (acc) begin
          pend      = 1'b1;
          pend_addr = acc_addr;
          cnt       = $urandom_range(mem_dmax, mem_dmin);
        end
        if (pend) begin
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pend           = 1'b0;
          end else begin
            cnt--;
          end
        end else if (mem_spurious && $urandom_range(0, 7) == 0) begin
          imem_rsp_valid = 1'b1;
        end
        imem_req_ready = mem_ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Reference model: the fetch stream restarts at RESET_PC on reset, jumps to the
  // word-aligned target on redirect, and otherwise advances by 4 per consumed instruction.
  initial begin : ref_model
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(RESET_PC);
      end else if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
      end else if (instr_valid === 1'b1 && instr_ready) begin
        exp_q.push_back(cur_pc + 32'd4);
      end
    end
  end

  // Monitor: every newly presented instruction is matched against the next expected PC.
  initial begin : monitor
    bit          prev_valid;
    int          idle;
    logic [31:0] exp_w;
    prev_valid = 1'b0;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        idle = 0;
      end else begin
        if (instr_valid === 1'b1 && !prev_valid) begin
          idle = 0;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL sb_unexpected_instr: got pc 0x%08h, expected no instruction", instr_pc);
          end else begin
            cur_pc = exp_q.pop_front();
            exp_w  = mem_word(cur_pc);
            checkOutput("sb_instr_pc", instr_pc, cur_pc);
            checkOutput("sb_instr", instr, exp_w);
            checkOutput("sb_op_code", {25'd0, op_code}, {25'd0, exp_w[6:0]});
            checkOutput("sb_func3", {29'd0, func3}, {29'd0, exp_w[14:12]});
            checkOutput("sb_func7", {25'd0, func7}, {25'd0, exp_w[31:25]});
          end
        end else if (instr_valid === 1'b1) begin
          checkOutput("sb_hold_instr", instr, mem_word(cur_pc));
          checkOutput("sb_hold_pc", instr_pc, cur_pc);
        end else begin
          idle++;
          if (idle > 100) begin
            failTimeout("sb_watchdog");
            idle = 0;
          end
        end
        if (instr_valid === 1'b1) checkOutput("sb_req_in_hold", {31'd0, imem_req_valid}, 32'd0);
        if (imem_req_valid === 1'b1) checkOutput("sb_addr_align", imem_addr & 32'h3, 32'd0);
        prev_valid = (instr_valid === 1'b1);
      end
    end
  end

  // Random decode backpressure and occasional redirects, some aimed at the top of memory.
  task automatic applyStimulus(input int cycles);
    mem_ready_always = 1'b0;
    mem_spurious     = 1'b1;
    mem_dmin         = 0;
    mem_dmax         = 3;
    for (int i = 0; i < cycles; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else                           redirect_pc = $urandom & 32'h0000_0FFF;
      end else begin
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
      end
      tick();
    end
    redirect_valid   = 1'b0;
    instr_ready      = 1'b1;
    mem_ready_always = 1'b1;
    mem_spurious     = 1'b0;
    mem_dmax         = 0;
    repeat (20) tick();
  endtask

  initial begin : main
    bit found;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    mem[32'h0] = 32'h0000_2083;
    mem[32'h4] = 32'h0020_8133;
    mem[32'h8] = 32'h0000_A023;

    $display("[TB] reset");
    repeat (3) begin
      tick();
      checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst_instr", instr, 32'h0000_0013);
    end
    checkOutput("rst_instr_pc", instr_pc, RESET_PC);
    rst = 1'b0;
    checkOutput("rel_cycle1_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    checkOutput("rel_cycle2_req", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("rel_cycle2_addr", imem_addr, RESET_PC);

    $display("[TB] sequential fetch");
    tick();
    checkOutput("seq_latency_early", {31'd0, instr_valid}, 32'd0);
    tick();
    checkOutput("seq0_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("seq0_pc", instr_pc, 32'h0);
    checkOutput("seq0_instr", instr, 32'h0000_2083);
    checkOutput("seq0_op_code", {25'd0, op_code}, 32'b0000011);
    checkOutput("seq0_func3", {29'd0, func3}, 32'b010);
    repeat (3) tick();
    checkOutput("seq1_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("seq1_pc", instr_pc, 32'h4);
    checkOutput("seq1_instr", instr, 32'h0020_8133);
    checkOutput("seq1_func7", {25'd0, func7}, 32'd0);
    checkOutput("seq1_op_code", {25'd0, op_code}, 32'b0110011);
    repeat (3) tick();
    checkOutput("seq2_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("seq2_pc", instr_pc, 32'h8);
    checkOutput("seq2_instr", instr, 32'h0000_A023);

    $display("[TB] backpressure");
    instr_ready = 1'b0;
    repeat (5) begin
      tick();
      checkOutput("bp_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("bp_instr", instr, 32'h0000_A023);
      checkOutput("bp_pc", instr_pc, 32'h8);
      checkOutput("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    checkOutput("bp_next_req", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("bp_next_addr", imem_addr, 32'hC);

    $display("[TB] redirect while waiting");
    mem_dmin = 3;
    mem_dmax = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      checkOutput("wr_no_stale_instr", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    if (!found) failTimeout("wr_next_req");
    checkOutput("wr_next_addr", imem_addr, 32'h0000_0100);
    mem_dmin = 0;
    mem_dmax = 0;

    $display("[TB] redirect while holding");
    waitValid("hr_wait_valid", 20, found);
    checkOutput("hr_pc", instr_pc, 32'h0000_0100);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checkOutput("hr_valid_dropped", {31'd0, instr_valid}, 32'd0);
    checkOutput("hr_next_req", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("hr_next_addr", imem_addr, 32'h0000_0200);

    $display("[TB] reset while waiting");
    man_ready     = 1'b1;
    man_rsp_valid = 1'b0;
    man_rsp_data  = '0;
    mem_manual    = 1'b1;
    tick();
    man_ready = 1'b0;
    checkOutput("rw_in_wait_req", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    man_rsp_valid = 1'b1;
    man_rsp_data  = 32'hDEAD_BEEF;
    tick();
    man_rsp_valid = 1'b0;
    man_ready     = 1'b1;
    mem_manual    = 1'b0;
    checkOutput("rw_stale_dropped", {31'd0, instr_valid}, 32'd0);
    checkOutput("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("rw_req_addr", imem_addr, RESET_PC);
    waitValid("rw_wait_valid", 20, found);
    checkOutput("rw_first_pc", instr_pc, RESET_PC);
    checkOutput("rw_first_instr", instr, 32'h0000_2083);

    $display("[TB] random traffic");
    applyStimulus(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : global_timeout
    #1_000_000;
    failTimeout("global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
